// File: rtl/cnn_mul_pkg.sv
// Shared widths, operand/product types and round-robin helper for the conv2 multiplier arbiter.
package cnn_mul_pkg;
  localparam int A_W = 14;
  localparam int B_W = 8;
  localparam int P_W = 23;

  typedef logic signed [A_W-1:0] mul_a_t;
  typedef logic signed [B_W-1:0] mul_b_t;
  typedef logic signed [P_W-1:0] mul_p_t;

  // First valid index strictly after ptr, wrapping modulo nreq (nreq <= 8).
  // Returns ptr when nothing is valid; callers gate with |valid.
  function automatic logic [2:0] rr_next(input logic [2:0] ptr, input logic [7:0] valid,
                                         input int unsigned nreq);
    logic [2:0]  idx;
    logic        found;
    int unsigned c;
    idx   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      c = ({29'd0, ptr} + k) % nreq;
      if (k <= nreq && !found && valid[c[2:0]]) begin
        idx   = c[2:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction
endpackage

// File: rtl/cnn_mul_arbiter_if.sv
// Requester/result bus of the shared multiplier arbiter.
interface cnn_mul_arbiter_if
  import cnn_mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [P_W-1:0]      rsp_p;
  logic                idle;

  modport master (output req_valid, req_a, req_b,
                  input  req_ready, rsp_valid, rsp_id, rsp_p, idle);
  modport slave  (input  req_valid, req_a, req_b,
                  output req_ready, rsp_valid, rsp_id, rsp_p, idle);
endinterface

// File: rtl/cnn_mul_pipe_core.sv
// Registered signed 14x8 multiplier with tag/valid pass-through.
// MUL_OUT_REG_EN adds an output product register (latency 3 instead of 2).
module cnn_mul_pipe_core
  import cnn_mul_pkg::*;
#(
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_v_i,
  input  mul_a_t          in_a_i,
  input  mul_b_t          in_b_i,
  input  logic [ID_W-1:0] in_id_i,
  output logic            out_v_o,
  output logic [ID_W-1:0] out_id_o,
  output mul_p_t          out_p_o,
  output logic            busy_o
);
`ifdef MUL_OUT_REG_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 2;
`endif

  logic [STAGES:1] vld_pipe_q;
  mul_a_t          a1_q;
  mul_b_t          b1_q;
  logic [ID_W-1:0] id1_q, id2_q;
  mul_p_t          p2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe_q <= '0;
    else        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_v_i};
  end

  // Data stages only load behind a valid so idle outputs keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q  <= '0;
      b1_q  <= '0;
      id1_q <= '0;
      p2_q  <= '0;
      id2_q <= '0;
    end else begin
      if (in_v_i) begin
        a1_q  <= in_a_i;
        b1_q  <= in_b_i;
        id1_q <= in_id_i;
      end
      if (vld_pipe_q[1]) begin
        p2_q  <= mul_p_t'(a1_q) * mul_p_t'(b1_q);
        id2_q <= id1_q;
      end
    end
  end

`ifdef MUL_OUT_REG_EN
  mul_p_t          p3_q;
  logic [ID_W-1:0] id3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p3_q  <= '0;
      id3_q <= '0;
    end else if (vld_pipe_q[2]) begin
      p3_q  <= p2_q;
      id3_q <= id2_q;
    end
  end

  assign out_p_o  = p3_q;
  assign out_id_o = id3_q;
`else
  assign out_p_o  = p2_q;
  assign out_id_o = id2_q;
`endif

  assign out_v_o = vld_pipe_q[STAGES];
  assign busy_o  = |vld_pipe_q;
endmodule

// File: rtl/cnn_mul_arbiter.sv
// Round-robin arbiter sharing one signed 14x8 multiplier among NREQ requesters.
// Pipeline depth follows MUL_OUT_REG_EN (see cnn_mul_pipe_core).
module cnn_mul_arbiter
  import cnn_mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  cnn_mul_arbiter_if.slave bus
);
  logic [ID_W-1:0] last_gnt_q, last_gnt_d, gnt_idx;
  logic [NREQ-1:0] ready;
  logic            any_v;
  mul_a_t          sel_a;
  mul_b_t          sel_b;
  logic            busy;

  // Grant never looks downstream: the pipe cannot stall.
  always_comb begin
    any_v      = |bus.req_valid;
    gnt_idx    = ID_W'(rr_next(3'(last_gnt_q), 8'(bus.req_valid), unsigned'(NREQ)));
    ready      = '0;
    if (any_v) ready[gnt_idx] = 1'b1;
    last_gnt_d = any_v ? gnt_idx : last_gnt_q;
    sel_a      = bus.req_a[int'(gnt_idx)*A_W +: A_W];
    sel_b      = bus.req_b[int'(gnt_idx)*B_W +: B_W];
  end

  // Pointer resets to the top index so requester 0 wins first.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) last_gnt_q <= ID_W'(NREQ-1);
    else           last_gnt_q <= last_gnt_d;
  end

  cnn_mul_pipe_core #(.ID_W(ID_W)) u_core (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .in_v_i   (any_v),
    .in_a_i   (sel_a),
    .in_b_i   (sel_b),
    .in_id_i  (gnt_idx),
    .out_v_o  (bus.rsp_valid),
    .out_id_o (bus.rsp_id),
    .out_p_o  (bus.rsp_p),
    .busy_o   (busy)
  );

  assign bus.req_ready = ready;
  assign bus.idle      = ~any_v & ~busy;
endmodule

// File: tb/tb_cnn_mul_arbiter.sv
// Scoreboard bench for cnn_mul_arbiter: reference round-robin model, in-order product queue.
module tb_cnn_mul_arbiter;
  import cnn_mul_pkg::*;
  localparam int NREQ = 4;
  localparam int ID_W = 2;
`ifdef MUL_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  cnn_mul_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();
  cnn_mul_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus.slave)
  );

  typedef struct {int id; int p; int cyc;} exp_t;
  exp_t            sb[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  int              cyc     = 0;
  int              m_last  = NREQ-1;
  int              wait_c[NREQ];
  logic [NREQ-1:0] gnt_seen = '0;
  int              last_p  = 0;
  int              last_id = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge ap_clk) cyc++;

  always @(negedge ap_rst_n) begin
    sb.delete();
    m_last = NREQ-1;
  end

  always @(negedge ap_clk) begin : mon
    logic [NREQ-1:0] v, exp_rdy;
    int   g, a, b, idx;
    exp_t e;
    v = bus.req_valid;
    chk("idle", 32'(bus.idle), 32'(v == '0 && sb.size() == 0));
    if (!ap_rst_n) begin
      chk("rst_vld", 32'(bus.rsp_valid), 0);
      chk("rst_id",  32'(bus.rsp_id), 0);
      chk("rst_p",   32'(bus.rsp_p), 0);
    end else if (bus.rsp_valid) begin
      if (sb.size() == 0) chk("rsp_extra", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_id",  32'(bus.rsp_id), 32'(e.id));
        chk("rsp_p",   32'($signed(bus.rsp_p)), 32'(e.p));
        chk("rsp_lat", 32'(cyc - e.cyc), 32'(LAT));
        last_p  = int'($signed(bus.rsp_p));
        last_id = int'(bus.rsp_id);
      end
    end
    g = -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (m_last + k) % NREQ;
      if (g < 0 && v[idx]) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("ready", 32'(bus.req_ready), 32'(exp_rdy));
    gnt_seen = bus.req_ready & v;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && exp_rdy[i]) begin
        chk("starve", 32'(wait_c[i] < NREQ), 1);
        wait_c[i] = 0;
      end else if (v[i]) wait_c[i]++;
      else wait_c[i] = 0;
    end
    if (g >= 0 && ap_rst_n) begin
      a = int'($signed(bus.req_a[g*A_W +: A_W]));
      b = int'($signed(bus.req_b[g*B_W +: B_W]));
      sb.push_back('{id: g, p: a * b, cyc: cyc});
      m_last = g;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[i*A_W +: A_W] = A_W'(a);
    bus.req_b[i*B_W +: B_W] = B_W'(b);
  endtask

  task automatic one_shot(input int i, input int a, input int b, input int exp_p, input string tag);
    set_op(i, a, b);
    bus.req_valid = NREQ'(1 << i);
    step(1);
    bus.req_valid = '0;
    step(LAT + 1);
    chk(tag, 32'(last_p), 32'(exp_p));
    chk({tag, "_id"}, 32'(last_id), 32'(i));
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    step(2);
    ap_rst_n = 1'b1;
    step(2);

    one_shot(2, 100, -3, -300, "single");
    one_shot(0, -8192, -128, 1048576, "ext_mm");
    one_shot(1, 8191, -128, -1048448, "ext_pm");
    one_shot(3, 0, 127, 0, "zero");

    // full contention, pointer currently at 3
    for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 2);
    bus.req_valid = '1;
    step(8);
    // wrap and skip: only r1, r3
    bus.req_valid = 4'b1010;
    step(3);
    bus.req_valid = '0;
    step(LAT + 2);

    // reset with two products in flight
    set_op(0, 55, 7);
    bus.req_valid = 4'b0001;
    step(2);
    ap_rst_n      = 1'b0;
    bus.req_valid = '0;
    step(2);
    ap_rst_n = 1'b1;
    set_op(0, 9, 9);
    set_op(1, -9, 9);
    bus.req_valid = 4'b0011;
    step(1);
    bus.req_valid = '0;
    step(LAT + 2);

    // random soak; waiting requesters mostly hold their request
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(bus.req_valid[i] && !gnt_seen[i] && $urandom_range(15) != 0)) begin
          bus.req_valid[i] = 1'($urandom_range(1));
          set_op(i, int'($urandom), int'($urandom));
        end
      end
      step(1);
    end
    bus.req_valid = '0;
    step(LAT + 3);
    chk("drain", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
